walnut_ctrl: RTL and testbench

- Per-tile controller for one wall-nut plant; the stage directly upstream of the walnut sprite renderer.
- Drives the renderer's position, enable and blink inputs: wVPos, wHPos, enable, blink.
- Tracks the plant's life: placed, eaten by zombies, destroyed, or shovelled.
- Reports health and a destroyed pulse to the game logic.

---
 rtl/walnut_ctrl.sv | 148 ++++++++++++++
 tb/tb_walnut_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/walnut_ctrl.sv
// walnut_ctrl -- per-tile controller for one wall-nut plant, feeding the
// walnut sprite renderer.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   place             one-cycle placement request; place_row/place_col are
//                     sampled with it
//   remove            one-cycle shovel request
//   zombie_bite       level: a zombie is eating this plant
//   wVPos, wHPos      sprite top row / left column in pixels (registered)
//   enable            plant present, the renderer draws it (registered)
//   blink             eyes-closed flag (registered)
//   health            remaining health (registered)
//   destroyed         one-cycle pulse on the edge where health reaches 0
//   crack_level       damage level 0..2 (only with WALNUT_CRACK_EN)
//
// Build option: define WALNUT_CRACK_EN to add the crack_level output.
module walnut_ctrl #(
  parameter logic [9:0] H_ORIGIN     = 10'd40,
  parameter logic [9:0] V_ORIGIN     = 10'd80,
  parameter logic [9:0] CELL_W       = 10'd64,
  parameter logic [9:0] CELL_H       = 10'd76,
  parameter logic [2:0] NUM_ROWS     = 3'd5,
  parameter logic [3:0] NUM_COLS     = 4'd9,
  parameter logic [7:0] HEALTH_MAX   = 8'd40,
  parameter logic [7:0] BITE_FRAMES  = 8'd15,
  parameter logic [7:0] BLINK_PERIOD = 8'd180,
  parameter logic [7:0] BLINK_LEN    = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       place,
  input  logic [2:0] place_row,
  input  logic [3:0] place_col,
  input  logic       remove,
  input  logic       zombie_bite,
  output logic [9:0] wVPos,
  output logic [9:0] wHPos,
  output logic       enable,
  output logic       blink,
  output logic [7:0] health,
  output logic       destroyed
`ifdef WALNUT_CRACK_EN
  ,
  output logic [1:0] crack_level
`endif
);

  typedef enum logic {EMPTY, ALIVE} state_t;

  state_t     state;
  logic [7:0] frameCnt;
  logic [7:0] biteCnt;

  logic       placeOk;
  logic [9:0] vCalc, hCalc;
  logic [7:0] frameNxt;

  assign placeOk  = place && (place_row < NUM_ROWS) && (place_col < NUM_COLS);
  assign vCalc    = V_ORIGIN + ({7'd0, place_row} * CELL_H);
  assign hCalc    = H_ORIGIN + ({6'd0, place_col} * CELL_W);
  assign frameNxt = (frameCnt == BLINK_PERIOD - 8'd1) ? 8'd0 : frameCnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      wVPos     <= '0;
      wHPos     <= '0;
      enable    <= 1'b0;
      blink     <= 1'b0;
      health    <= '0;
      destroyed <= 1'b0;
      frameCnt  <= '0;
      biteCnt   <= '0;
    end else begin
      destroyed <= 1'b0;
      case (state)
        EMPTY: begin
          if (placeOk) begin
            state    <= ALIVE;
            enable   <= 1'b1;
            wVPos    <= vCalc;
            wHPos    <= hCalc;
            health   <= HEALTH_MAX;
            frameCnt <= '0;
            biteCnt  <= '0;
            blink    <= 1'b0;
          end
        end
        ALIVE: begin
          if (remove) begin
            // Shovel beats any bite or tick arriving in the same cycle.
            state  <= EMPTY;
            enable <= 1'b0;
            health <= '0;
            blink  <= 1'b0;
          end else begin
            // Blink follows the counter value from before this edge.
            blink <= (frameCnt >= BLINK_PERIOD - BLINK_LEN);
            if (frame_tick) frameCnt <= frameNxt;
            if (!zombie_bite) begin
              biteCnt <= '0;
            end else if (frame_tick) begin
              if (biteCnt == BITE_FRAMES - 8'd1) begin
                biteCnt <= '0;
                if (health == 8'd1) begin
                  state     <= EMPTY;
                  enable    <= 1'b0;
                  blink     <= 1'b0;
                  health    <= '0;
                  destroyed <= 1'b1;
                end else if (health != 8'd0) begin
                  health <= health - 8'd1;
                end
              end else begin
                biteCnt <= biteCnt + 8'd1;
              end
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef WALNUT_CRACK_EN
  // Thresholds at 10 bits: 40 -> 26 and 13 with the default health.
  localparam logic [9:0] CRACK_HI = ({2'd0, HEALTH_MAX} * 10'd2) / 10'd3;
  localparam logic [9:0] CRACK_LO = {2'd0, HEALTH_MAX} / 10'd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crack_level <= 2'd0;
    end else if (!enable) begin
      crack_level <= 2'd0;
    end else if ({2'd0, health} > CRACK_HI) begin
      crack_level <= 2'd0;
    end else if ({2'd0, health} > CRACK_LO) begin
      crack_level <= 2'd1;
    end else begin
      crack_level <= 2'd2;
    end
  end
`endif

endmodule

// File: tb/tb_walnut_ctrl.sv
module tb_walnut_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, place = 1'b0, remove = 1'b0, zombie_bite = 1'b0;
  logic [2:0] place_row = '0;
  logic [3:0] place_col = '0;
  logic [9:0] wVPos, wHPos;
  logic       enable, blink, destroyed;
  logic [7:0] health;
`ifdef WALNUT_CRACK_EN
  logic [1:0] crack;
`endif

  walnut_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .place(place),
    .place_row(place_row), .place_col(place_col), .remove(remove),
    .zombie_bite(zombie_bite), .wVPos(wVPos), .wHPos(wHPos),
    .enable(enable), .blink(blink), .health(health), .destroyed(destroyed)
`ifdef WALNUT_CRACK_EN
    , .crack_level(crack)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: counts ticks and bitten ticks since placement and
  // derives outputs arithmetically from them.
  int mAlive, mV, mH, mTicks, mStreak, mHealth, mBlink, mDestr;
  int pAlive, pHealth;
  int destrSeen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mAlive = 0; mV = 0; mH = 0; mTicks = 0; mStreak = 0;
    mHealth = 0; mBlink = 0; mDestr = 0; pAlive = 0; pHealth = 0;
  endtask

  task automatic modelStep(input int ft, input int pl, input int r, input int c,
                           input int rm, input int zb);
    pAlive = mAlive; pHealth = mHealth;
    mDestr = 0;
    if (mAlive == 0) begin
      if (pl != 0 && r < 5 && c < 9) begin
        mAlive = 1; mV = 80 + r * 76; mH = 40 + c * 64;
        mHealth = 40; mTicks = 0; mStreak = 0; mBlink = 0;
      end
    end else if (rm != 0) begin
      mAlive = 0; mHealth = 0; mBlink = 0;
    end else begin
      mBlink = ((mTicks % 180) >= 172) ? 1 : 0;
      if (ft != 0) mTicks++;
      if (zb == 0) mStreak = 0;
      else if (ft != 0) begin
        mStreak++;
        if (mStreak % 15 == 0) begin
          mHealth--;
          if (mHealth == 0) begin
            mAlive = 0; mBlink = 0; mDestr = 1;
          end
        end
      end
    end
  endtask

  task automatic checkAll();
    chk("enable", enable, mAlive);
    chk("health", health, mHealth);
    chk("blink", blink, mBlink);
    chk("destroyed", destroyed, mDestr);
    if (mAlive != 0) begin
      chk("wVPos", wVPos, mV);
      chk("wHPos", wHPos, mH);
    end
`ifdef WALNUT_CRACK_EN
    chk("crack", crack, (pAlive == 0) ? 0 : (pHealth > 26) ? 1'b0 * 0 : (pHealth > 13) ? 1 : 2);
`endif
    if (destroyed === 1'b1) destrSeen++;
  endtask

  // One clock: drive inputs, take the edge, advance model, check #1 later.
  task automatic cyc(input int ft, input int pl, input int r, input int c,
                     input int rm, input int zb);
    frame_tick = (ft != 0); place = (pl != 0); place_row = 3'(r);
    place_col = 4'(c); remove = (rm != 0); zombie_bite = (zb != 0);
    @(posedge clk);
    modelStep(ft, pl, r, c, rm, zb);
    #1;
    checkAll();
    frame_tick = 0; place = 0; remove = 0;
  endtask

  task automatic ticks(input int n, input int zb);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0, 0, zb);
      cyc(0, 0, 0, 0, 0, zb);
    end
  endtask

  initial begin
    modelReset();
    destrSeen = 0;
    #12;
    chk("rst_enable", enable, 0);
    chk("rst_health", health, 0);
    chk("rst_wVPos", wVPos, 0);
    chk("rst_destroyed", destroyed, 0);
    @(negedge clk) rst = 0;

    // Place row 2 col 3.
    cyc(0, 1, 2, 3, 0, 0);
    chk("place_v232", wVPos, 232);
    chk("place_h232", wHPos, 232);
    chk("place_health40", health, 40);

    // Blink window over two periods.
    ticks(172, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("blink_rise", blink, 1);
    ticks(8, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("blink_fall", blink, 0);
    ticks(185, 0);

    // Broken bite streak loses nothing.
    ticks(14, 1);
    cyc(0, 0, 0, 0, 0, 0);
    ticks(14, 1);
    chk("streak_health40", health, 40);
    cyc(0, 0, 0, 0, 0, 0);

    // Place while alive is ignored.
    cyc(0, 1, 0, 0, 0, 0);
    chk("hold_v", wVPos, 232);

    // Full destruction: 600 bitten ticks.
    destrSeen = 0;
    ticks(600, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("destr_once", destrSeen, 1);
    chk("destr_enable", enable, 0);

    // Out-of-range placements.
    cyc(0, 1, 5, 0, 0, 0);
    cyc(0, 1, 0, 9, 0, 0);
    chk("oob_enable", enable, 0);

    // Remove with tick and a ripe bite counter: no health change, no pulse.
    cyc(0, 1, 4, 8, 0, 0);
    ticks(14, 1);
    cyc(1, 0, 0, 0, 1, 1);
    chk("rm_destroyed", destroyed, 0);
    chk("rm_enable", enable, 0);

    // Place + remove in EMPTY: place wins.
    cyc(0, 1, 1, 1, 1, 0);
    chk("plrm_enable", enable, 1);

    // Asynchronous reset between edges while biting.
    ticks(20, 1);
    #2 rst = 1;
    #1;
    chk("async_enable", enable, 0);
    chk("async_health", health, 0);
    chk("async_wHPos", wHPos, 0);
    modelReset();
    @(negedge clk) rst = 0;

    // Randomized traffic against the model.
    begin
      int zb = 0;
      for (int i = 0; i < 6000; i++) begin
        if (zb != 0) begin
          if ($urandom_range(0, 399) == 0) zb = 0;
        end else if ($urandom_range(0, 19) == 0) zb = 1;
        cyc(($urandom_range(0, 1)),
            ($urandom_range(0, 29) == 0) ? 1 : 0,
            $urandom_range(0, 7), $urandom_range(0, 15),
            ($urandom_range(0, 299) == 0) ? 1 : 0, zb);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
